// File: rtl/frame_draw_ctrl.sv
// Frame redraw sequencer feeding vga_adapter: sweeps the background ROM,
// then optionally overlays a clipped, colour-keyed sprite.
module frame_draw_ctrl #(
  parameter int unsigned X_MAX       = 159,
  parameter int unsigned Y_MAX       = 119,
  parameter int unsigned SPR_DIM     = 16,
  parameter logic [2:0]  TRANSPARENT = 3'b000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        draw_req_i,
  input  logic [1:0]  screen_sel_i,
  input  logic        sprite_en_i,
  input  logic [7:0]  sprite_x_i,
  input  logic [6:0]  sprite_y_i,
  output logic [14:0] bg_addr_o,
  output logic [1:0]  bg_sel_o,
  input  logic [2:0]  bg_color_i,
  output logic [7:0]  spr_addr_o,
  input  logic [2:0]  spr_color_i,
  output logic [7:0]  vga_x_o,
  output logic [6:0]  vga_y_o,
  output logic [2:0]  vga_color_o,
  output logic        plot_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW = $clog2(SPR_DIM);

  localparam logic [7:0]    X_LAST    = 8'(X_MAX);
  localparam logic [6:0]    Y_LAST    = 7'(Y_MAX);
  localparam logic [CW-1:0] C_LAST    = CW'(SPR_DIM - 1);
  localparam logic [8:0]    PX_LIM    = 9'(X_MAX);
  localparam logic [7:0]    PY_LIM    = 8'(Y_MAX);
  localparam logic [14:0]   ROW_PITCH = 15'(X_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    BG,
    BG_FLUSH,
    SPR,
    SPR_FLUSH,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    bx_q, bx_d;
  logic [6:0]    by_q, by_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    sel_q, sel_d;
  logic          spr_en_q, spr_en_d;
  logic [7:0]    spr_x_q, spr_x_d;
  logic [6:0]    spr_y_q, spr_y_d;

  // Pipeline stage aligned with the one-cycle ROM read latency.
  logic          pvld_q, pvld_d;
  logic          pspr_q, pspr_d;
  logic [8:0]    px_q, px_d;
  logic [7:0]    py_q, py_d;

  logic          spr_visible;

  // State, counters, latched request parameters and pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sel_q    <= '0;
      spr_en_q <= 1'b0;
      spr_x_q  <= '0;
      spr_y_q  <= '0;
      pvld_q   <= 1'b0;
      pspr_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sel_q    <= sel_d;
      spr_en_q <= spr_en_d;
      spr_x_q  <= spr_x_d;
      spr_y_q  <= spr_y_d;
      pvld_q   <= pvld_d;
      pspr_q   <= pspr_d;
      px_q     <= px_d;
      py_q     <= py_d;
    end
  end

  // Next-state logic: sweep sequencing and pipeline capture of issued pixels.
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    row_d    = row_q;
    col_d    = col_q;
    sel_d    = sel_q;
    spr_en_d = spr_en_q;
    spr_x_d  = spr_x_q;
    spr_y_d  = spr_y_q;
    pvld_d   = 1'b0;
    pspr_d   = 1'b0;
    px_d     = px_q;
    py_d     = py_q;

    unique case (state_q)
      IDLE: begin
        if (draw_req_i) begin
          sel_d    = screen_sel_i;
          spr_en_d = sprite_en_i;
          spr_x_d  = sprite_x_i;
          spr_y_d  = sprite_y_i;
          bx_d     = '0;
          by_d     = '0;
          row_d    = '0;
          col_d    = '0;
          state_d  = BG;
        end
      end
      BG: begin
        pvld_d = 1'b1;
        px_d   = {1'b0, bx_q};
        py_d   = {1'b0, by_q};
        if (bx_q == X_LAST) begin
          bx_d = '0;
          if (by_q == Y_LAST) begin
            state_d = BG_FLUSH;
          end else begin
            by_d = by_q + 7'd1;
          end
        end else begin
          bx_d = bx_q + 8'd1;
        end
      end
      BG_FLUSH: begin
        state_d = spr_en_q ? SPR : DONE;
      end
      SPR: begin
        pvld_d = 1'b1;
        pspr_d = 1'b1;
        // Widened sums let the clip test see targets past the screen edge.
        px_d   = 9'(spr_x_q) + 9'(col_q);
        py_d   = 8'(spr_y_q) + 8'(row_q);
        if (col_q == C_LAST) begin
          col_d = '0;
          if (row_q == C_LAST) begin
            state_d = SPR_FLUSH;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      SPR_FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bg_addr_o   = 15'(by_q) * ROW_PITCH + 15'(bx_q);
  assign spr_addr_o  = 8'({row_q, col_q});
  assign bg_sel_o    = sel_q;

  assign spr_visible = (spr_color_i != TRANSPARENT) && (px_q <= PX_LIM) && (py_q <= PY_LIM);

  assign vga_x_o     = px_q[7:0];
  assign vga_y_o     = py_q[6:0];
  assign vga_color_o = pvld_q ? (pspr_q ? spr_color_i : bg_color_i) : 3'b000;
  assign plot_o      = pvld_q && (!pspr_q || spr_visible);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Scoreboard bench for frame_draw_ctrl with bench-side background/sprite ROMs.
module tb_frame_draw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_req;
  logic [1:0]  screen_sel;
  logic        sprite_en;
  logic [7:0]  sprite_x;
  logic [6:0]  sprite_y;
  logic [14:0] bg_addr;
  logic [1:0]  bg_sel;
  logic [2:0]  bg_color;
  logic [7:0]  spr_addr;
  logic [2:0]  spr_color;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        plot;
  logic        busy;
  logic        done;

  frame_draw_ctrl #(
    .X_MAX(159),
    .Y_MAX(119),
    .SPR_DIM(16),
    .TRANSPARENT(3'b000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .draw_req_i(draw_req),
    .screen_sel_i(screen_sel),
    .sprite_en_i(sprite_en),
    .sprite_x_i(sprite_x),
    .sprite_y_i(sprite_y),
    .bg_addr_o(bg_addr),
    .bg_sel_o(bg_sel),
    .bg_color_i(bg_color),
    .spr_addr_o(spr_addr),
    .spr_color_i(spr_color),
    .vga_x_o(vga_x),
    .vga_y_o(vga_y),
    .vga_color_o(vga_color),
    .plot_o(plot),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t       exp_q[$];
  logic [2:0] spr_mem [256];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc = 0;
  int         exp_len = 0;
  bit         frame_active = 0;
  int         done_seen = 0;

  // Background image content: depends on address and selected screen.
  function automatic logic [2:0] bg_f(input int a, input int s);
    int v;
    v = (a ^ (a >> 4)) + s * 3 + (a >> 9);
    return v[2:0];
  endfunction

  // Synchronous ROMs, one-cycle read latency.
  always @(posedge clk) begin
    bg_color  <= bg_f(int'(bg_addr), int'(bg_sel));
    spr_color <= spr_mem[spr_addr];
    cyc       <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: raster-order background, then sprite cells that are opaque and on screen.
  task automatic push_frame(input int sel, input bit en, input int sx, input int sy);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back('{x, y, int'(bg_f(160 * y + x, sel))});
    if (en) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          int px, py, col;
          px  = sx + c;
          py  = sy + r;
          col = int'(spr_mem[r * 16 + c]);
          if (col != 0 && px <= 159 && py <= 119)
            exp_q.push_back('{px, py, col});
        end
    end
    exp_len = en ? 19200 + 2 + 257 : 19200 + 2;
  endtask

  // Monitor: every plot pops one expected pixel; done checks length and drain.
  always @(negedge clk) begin
    if (plot) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL plot_unexpected: got plot at (%0d,%0d), expected none", vga_x, vga_y);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_color) != e.c) begin
          n_err++;
          $display("FAIL pixel: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                   vga_x, vga_y, vga_color, e.x, e.y, e.c);
        end
      end
    end
    if (done) begin
      n_cmp++;
      if (!frame_active || (cyc - acc + 1) != exp_len || exp_q.size() != 0) begin
        n_err++;
        $display("FAIL done: got len %0d active %0d left %0d, expected len %0d active 1 left 0",
                 cyc - acc + 1, frame_active, exp_q.size(), exp_len);
      end
      frame_active = 0;
      done_seen++;
    end
  end

  task automatic start_frame(input int sel, input bit en, input int sx, input int sy);
    @(posedge clk);
    #1;
    screen_sel = 2'(sel);
    sprite_en  = en;
    sprite_x   = 8'(sx);
    sprite_y   = 7'(sy);
    draw_req   = 1'b1;
    push_frame(sel, en, sx, sy);
    acc          = cyc + 1;
    frame_active = 1;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    chk("bg_sel_latched", int'(bg_sel), sel);
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_cmp++;
    if (done_seen == start) begin
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", budget);
      frame_active = 0;
      exp_q.delete();
    end
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic abort_frame();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    frame_active = 0;
    chk("plot_after_reset", int'(plot), 0);
    chk("busy_after_reset", int'(busy), 0);
    chk("done_after_reset", int'(done), 0);
  endtask

  initial begin
    int d;
    rst = 1'b1;
    draw_req = 1'b0;
    screen_sel = 2'b00;
    sprite_en = 1'b0;
    sprite_x = '0;
    sprite_y = '0;
    for (int i = 0; i < 256; i++) spr_mem[i] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bg_sel", int'(bg_sel), 0);
    chk("rst_bg_addr", int'(bg_addr), 0);
    chk("rst_spr_addr", int'(spr_addr), 0);
    chk("rst_vga_xyc", int'({vga_x, vga_y, vga_color}), 0);
    rst = 1'b0;

    // Background only, normal screen.
    start_frame(1, 1'b0, $urandom_range(255, 0), $urandom_range(127, 0));
    wait_done(20000);

    // Diagonal sprite at (10,20).
    for (int i = 0; i < 16; i++) spr_mem[i * 17] = 3'(1 + (i % 7));
    start_frame($urandom_range(3, 0), 1'b1, 10, 20);
    wait_done(20000);

    // Fully opaque sprite clipped at the bottom-right corner.
    for (int i = 0; i < 256; i++) spr_mem[i] = 3'($urandom_range(7, 1));
    start_frame($urandom_range(3, 0), 1'b1, 150, 110);
    wait_done(20000);

    // Random sprite with transparency; mid-frame request and input changes ignored.
    for (int i = 0; i < 256; i++) spr_mem[i] = 3'($urandom_range(7, 0));
    start_frame(1, 1'b1, $urandom_range(170, 0), $urandom_range(127, 0));
    repeat (498) @(posedge clk);
    #1;
    screen_sel = 2'b10;
    sprite_en  = 1'b0;
    sprite_x   = 8'($urandom_range(255, 0));
    sprite_y   = 7'($urandom_range(127, 0));
    draw_req   = 1'b1;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    chk("bg_sel_midframe", int'(bg_sel), 1);
    wait_done(20000);
    d = done_seen;
    repeat (40) @(posedge clk);
    #1;
    chk("single_done", done_seen, d);

    // Fresh request latches 10, then reset around cycle 1000.
    start_frame(2, 1'b1, $urandom_range(170, 0), $urandom_range(127, 0));
    repeat (997) @(posedge clk);
    d = done_seen;
    abort_frame();
    repeat (60) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_seen, d);
    chk("busy_idle_after_abort", int'(busy), 0);

    // Restart begins at (0,0); cut short by another reset.
    start_frame(3, 1'b0, 0, 0);
    repeat (300) @(posedge clk);
    abort_frame();

    // Request coincident with reset: reset wins.
    @(posedge clk);
    #1;
    screen_sel = 2'b01;
    rst = 1'b1;
    draw_req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    draw_req = 1'b0;
    chk("busy_req_with_reset", int'(busy), 0);
    chk("bg_sel_req_with_reset", int'(bg_sel), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_stays_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_draw_ctrl.md
Name: frame_draw_ctrl

Overview:
- Sequencing stage directly upstream of vga_adapter. Replaces the manual KEY[3] plot.
- On a draw request, sweeps the full 160x120 background ROM (address 160*y+x) and streams registered x/y/colour/plot to the adapter.
- Optionally overlays a 16x16 tetris-block sprite at (sprite_x, sprite_y), with transparency and screen-edge clipping.
- Latches the screen select for the duration of the frame so the background mux input stays stable mid-sweep.

Parameters:
X_MAX, 159, last column index.
Y_MAX, 119, last row index.
SPR_DIM, 16, sprite width and height in pixels (power of 2).
TRANSPARENT, 3'b000, sprite colour that is not plotted.

Ports:
Clock  in  1  system clock (CLOCK_50 domain).
Reset  in  1  synchronous, active-high reset.
draw_req  in  1  single-cycle pulse that starts a frame redraw.
screen_sel  in  2  background select: 00 slow, 01 normal, 10 fast, 11 game.
sprite_en  in  1  when 1, draw the sprite pass after the background pass.
sprite_x  in  8  sprite top-left x.
sprite_y  in  7  sprite top-left y.
bg_addr  out  15  background ROM address, 160*by+bx.
bg_sel  out  2  latched screen_sel; drives the external background mux.
bg_color  in  3  background ROM data; valid 1 cycle after bg_addr.
spr_addr  out  8  sprite ROM address {row[3:0], col[3:0]}.
spr_color  in  3  sprite ROM data; valid 1 cycle after spr_addr.
vga_x  out  8  pixel x to the adapter.
vga_y  out  7  pixel y to the adapter.
vga_color  out  3  pixel colour to the adapter.
plot  out  1  write strobe to the adapter.
busy  out  1  high from the cycle after an accepted request through the done cycle.
done  out  1  one-cycle pulse when the frame is finished.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; bg_sel = 00.
- FSM states: IDLE, BG, BG_FLUSH, SPR, SPR_FLUSH, DONE.
- IDLE:
  - On draw_req, latch screen_sel into bg_sel, latch sprite_en/sprite_x/sprite_y, clear bx, by, row, col; next state BG.
  - draw_req while not in IDLE is ignored and not queued.
- BG:
  - Each cycle: issue bg_addr = 160*by + bx (15-bit).
  - Advance bx 0..X_MAX; on wrap, bx = 0 and by++.
  - After issuing (X_MAX, Y_MAX), go to BG_FLUSH.
- Pipeline:
  - A 1-cycle register stage carries the issued coordinate and a valid bit alongside ROM latency.
  - vga_x/vga_y/vga_color/plot update the cycle after the address was issued, with colour = ROM data.
  - Latency from address to plot is exactly 1 cycle.
- BG_FLUSH:
  - Emits the final background pixel.
  - Next state SPR if the latched sprite_en = 1, else DONE.
- SPR:
  - Each cycle: spr_addr = {row, col}; col increments and wraps into row.
  - After issuing (SPR_DIM-1, SPR_DIM-1), go to SPR_FLUSH.
  - The pipeline carries the target px = sprite_x + col and py = sprite_y + row, computed at 9 and 8 bits respectively.
  - plot = 1 only if spr_color != TRANSPARENT, px <= X_MAX and py <= Y_MAX.
  - Clipped or transparent pixels keep plot = 0; vga_x/y are still updated, truncated to 8 and 7 bits.
- SPR_FLUSH: emits the final sprite pixel, then goes to DONE.
- DONE: done = 1 for one cycle, busy = 1, plot = 0; then IDLE.
- busy: high from the cycle after the request is accepted through the DONE cycle; low in IDLE.
- Frame length (request accepted to done pulse):
  - Background only: 19200 + 1 + 1 cycles.
  - With sprite: additionally 256 + 1 cycles.
- Inputs sampled at request: screen_sel, sprite_* and sprite_en changes mid-frame have no effect. bg_sel changes only in IDLE on an accepted request.
- Reset mid-frame: immediate return to IDLE next edge; plot, busy and done = 0; no done pulse.
- Simultaneous draw_req and Reset: Reset wins.
- plot is never asserted outside the BG/BG_FLUSH/SPR/SPR_FLUSH pipeline window.

Test Plan:
- Reset, then draw_req with screen_sel = 01, sprite_en = 0 -> bg_sel = 01. First plot is 1 cycle after the first bg_addr = 0, at (0,0). Plot at (159,0) is followed by (0,1). Last plot at (159,119) with bg_addr = 19199. done pulses once at cycle 19202, and exactly 19200 plots occur.
- sprite_en = 1, sprite at (10,20), sprite ROM with diagonal cells non-zero and others 000 -> after the background pass, exactly 16 sprite plots at (10+i, 20+i), colours matching the ROM. done occurs after 19202 + 257 cycles.
- Sprite at (150,110), all cells opaque -> only cols 0..9 and rows 0..9 plot (100 plots). No plot has vga_x > 159 or vga_y > 119.
- Change screen_sel from 01 to 10 and pulse draw_req again at cycle 500 of a frame -> bg_sel stays 01, the request is ignored, and there is a single done. A fresh draw_req after done latches 10.
- Assert Reset at cycle 1000 of a frame -> the next cycle has plot = 0, busy = 0, done never pulses. A subsequent draw_req restarts at (0,0).
- draw_req and Reset in the same cycle -> stays IDLE with busy = 0.
